// File: rtl/bounded_counter_pkg.sv
// Shared constants and helpers for the bounded up/down counter.
// The direction and mode encodings match the raw reverse/saturate inputs.
package bounded_counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Widest counter the clamp helper supports; callers zero-extend into it.
    localparam int CLAMP_W = 64;

    // Returns min(max(value, lo), hi); lo is applied first so hi wins when lo > hi.
    function automatic logic [CLAMP_W-1:0] clamp(
        input logic [CLAMP_W-1:0] value,
        input logic [CLAMP_W-1:0] lo,
        input logic [CLAMP_W-1:0] hi
    );
        logic [CLAMP_W-1:0] result;
        result = value;
        if (result < lo) result = lo;
        if (result > hi) result = hi;
        return result;
    endfunction

endpackage

// File: rtl/bound_step_calc.sv
// Combinational next-value unit: one up/down step bounded by [limit_lo, limit_hi],
// with wrap or saturate on overflow and snap-to-bound when already out of range.
module bound_step_calc
    import bounded_counter_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  count_value,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit_lo,
    input  logic [WIDTH-1:0]  limit_hi,
    input  logic              reverse,
    input  logic              saturate,
    output logic [WIDTH-1:0]  next_value,
    output logic              crossed,
    output logic              out_of_range
);

    logic [WIDTH:0] step_ext;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign sum      = {1'b0, count_value} + step_ext;
    assign diff     = {1'b0, count_value} - step_ext;

    // Pick the next count: snap into range first, then hold on zero step, then step with bound handling.
    always_comb begin
        next_value   = count_value;
        crossed      = 1'b0;
        out_of_range = (count_value > limit_hi) || (count_value < limit_lo);
        if (out_of_range) begin
            next_value = (count_value > limit_hi) ? limit_hi : limit_lo;
        end else if (step == '0) begin
            next_value = count_value;
        end else if (reverse == DIR_UP) begin
            if (sum <= {1'b0, limit_hi}) begin
                next_value = sum[WIDTH-1:0];
            end else begin
                next_value = (saturate == MODE_SAT) ? limit_hi : limit_lo;
                crossed    = 1'b1;
            end
        end else begin
            if (!diff[WIDTH] && (diff[WIDTH-1:0] >= limit_lo)) begin
                next_value = diff[WIDTH-1:0];
            end else begin
                next_value = (saturate == MODE_WRAP) ? limit_hi : limit_lo;
                crossed    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bounded_up_down_counter.sv
// Parametrised up/down counter with runtime step, programmable bounds,
// wrap/saturate mode, clamped parallel load and bound status flags.
module bounded_up_down_counter
    import bounded_counter_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              reverse,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit_lo,
    input  logic [WIDTH-1:0]  limit_hi,
    input  logic              saturate,
    output logic [WIDTH-1:0]  out,
    output logic              at_max,
    output logic              at_min,
    output logic              bound_hit,
    output logic              cfg_err
);

    logic [WIDTH-1:0] next_value;
    logic             crossed;
    logic             out_of_range;
    logic [WIDTH-1:0] load_clamped;

    bound_step_calc #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_step_calc (
        .count_value  (out),
        .step         (step),
        .limit_lo     (limit_lo),
        .limit_hi     (limit_hi),
        .reverse      (reverse),
        .saturate     (saturate),
        .next_value   (next_value),
        .crossed      (crossed),
        .out_of_range (out_of_range)
    );

    assign load_clamped = WIDTH'(clamp(CLAMP_W'(load_value), CLAMP_W'(limit_lo), CLAMP_W'(limit_hi)));

    assign cfg_err = (limit_lo > limit_hi);
    assign at_max  = (out == limit_hi);
    assign at_min  = (out == limit_lo);

    // Count register with priority reset > bad config hold > load > count > hold; a range snap never pulses bound_hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            bound_hit <= 1'b0;
        end else if (cfg_err) begin
            bound_hit <= 1'b0;
        end else if (load) begin
            out       <= load_clamped;
            bound_hit <= 1'b0;
        end else if (enable) begin
            out       <= next_value;
            bound_hit <= crossed && !out_of_range;
        end else begin
            bound_hit <= 1'b0;
        end
    end

endmodule
